// File: rtl/pio_in_pkg.sv
// Shared register map and edge-mode encodings for the PIO edge-capture block.
package pio_in_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_MODE    = 2'd1;
    localparam logic [1:0] ADDR_MASK    = 2'd2;
    localparam logic [1:0] ADDR_CAPTURE = 2'd3;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Qualified edge for one bit given its 2-bit mode and current/previous samples.
    function automatic logic edge_hit(input logic [1:0] m, input logic s, input logic p);
        logic rise;
        logic fall;
        rise = s & ~p;
        fall = ~s & p;
        case (m)
            MODE_NONE: edge_hit = 1'b0;
            MODE_RISE: edge_hit = rise;
            MODE_FALL: edge_hit = fall;
            MODE_BOTH: edge_hit = rise | fall;
            default:   edge_hit = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pio_sync_chain.sv
// Multi-flop synchronizer bringing asynchronous inputs into the clk domain.
module pio_sync_chain #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ff <= '0;
        end else begin
            ff[0] <= d;
            for (int s = 1; s < STAGES; s++) ff[s] <= ff[s-1];
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pio_in_edge_irq.sv
// Parallel input port with per-bit edge capture, interrupt mask and level irq.
module pio_in_edge_irq
    import pio_in_pkg::*;
#(
    parameter int          WIDTH       = 16,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] MODE_RESET  = 32'h5555_5555,
    parameter int          BIT_CLEAR   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0]   sync;
    logic [WIDTH-1:0]   prev;
    logic [2*WIDTH-1:0] mode_r;
    logic [WIDTH-1:0]   mask_r;
    logic [WIDTH-1:0]   cap_r;
    logic [WIDTH-1:0]   ev;
    logic [WIDTH-1:0]   clr;
    logic [31:0]        rd_next;
    logic               wr;

    pio_sync_chain #(.WIDTH(WIDTH), .STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (in_port),
        .q       (sync)
    );

    assign wr = chipselect & ~write_n;

    always_comb begin
        ev = '0;
        for (int i = 0; i < WIDTH; i++) ev[i] = edge_hit(mode_r[2*i +: 2], sync[i], prev[i]);
    end

    always_comb begin
        clr = '0;
        if (wr && address == ADDR_CAPTURE)
            clr = (BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : '1;
    end

    always_comb begin
        rd_next = '0;
        case (address)
            ADDR_DATA:    rd_next[WIDTH-1:0]   = sync;
            ADDR_MODE:    rd_next[2*WIDTH-1:0] = mode_r;
            ADDR_MASK:    rd_next[WIDTH-1:0]   = mask_r;
            ADDR_CAPTURE: rd_next[WIDTH-1:0]   = cap_r;
            default:      rd_next              = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev     <= '0;
            mode_r   <= MODE_RESET[2*WIDTH-1:0];
            mask_r   <= '0;
            cap_r    <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            prev     <= sync;
            readdata <= rd_next;
            irq      <= |(cap_r & mask_r);
            if (wr && address == ADDR_MODE) mode_r <= writedata[2*WIDTH-1:0];
            if (wr && address == ADDR_MASK) mask_r <= writedata[WIDTH-1:0];
            // Set after clear so an edge coinciding with a clear is never lost.
            cap_r    <= (cap_r & ~clr) | ev;
        end
    end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed bench: default, clear-all and 4-bit variants share one bus.
module tb_pio_in_edge_irq;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [15:0] in_port;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int checks = 0;
    int errors = 0;

    pio_in_edge_irq u_dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0)
    );

    pio_in_edge_irq #(.BIT_CLEAR(0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1)
    );

    pio_in_edge_irq #(.WIDTH(4)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port[3:0]),
        .readdata(rd2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Bus tasks are entered just after a falling edge and return after the next one.
    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        address = a;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        #1;
        chk("rst_rd", rd0, 32'h0);
        chk("rst_irq", {31'h0, irq0}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        bus_rd(2'd1);
        chk("mode_rst", rd0, 32'h5555_5555);
        chk("mode_rst_w4", rd2, 32'h0000_0055);
        bus_rd(2'd2);
        chk("mask_rst", rd0, 32'h0);
        bus_rd(2'd3);
        chk("cap_rst", rd0, 32'h0);

        // Rising edge on bit 3: capture visible in readdata one cycle after it sets.
        address = 2'd3;
        in_port = 16'h0008;
        repeat (3) @(negedge clk);
        chk("cap_lat_early", rd0, 32'h0);
        @(negedge clk);
        chk("cap_lat", rd0, 32'h8);
        chk("cap_lat_w4", rd2, 32'h8);
        chk("irq_masked", {31'h0, irq0}, 32'h0);
        bus_rd(2'd0);
        chk("data_rd", rd0, 32'h8);

        // Masked edge drives irq one cycle after capture.
        bus_wr(2'd3, 32'h8);
        bus_wr(2'd2, 32'h8);
        in_port = 16'h0000;
        repeat (5) @(negedge clk);
        bus_rd(2'd3);
        chk("no_fall_rise_mode", rd0, 32'h0);
        in_port = 16'h0008;
        repeat (3) @(negedge clk);
        chk("irq_early", {31'h0, irq0}, 32'h0);
        @(negedge clk);
        chk("irq_set", {31'h0, irq0}, 32'h1);
        bus_wr(2'd3, 32'h8);
        chk("irq_hold", {31'h0, irq0}, 32'h1);
        @(negedge clk);
        chk("irq_clr", {31'h0, irq0}, 32'h0);
        bus_rd(2'd3);
        chk("cap_clr", rd0, 32'h0);

        // Falling-only mode on bit 3.
        bus_wr(2'd1, 32'h0000_0080);
        in_port = 16'h0000;
        repeat (5) @(negedge clk);
        bus_rd(2'd3);
        chk("fall_cap", rd0, 32'h8);
        bus_wr(2'd3, 32'h8);
        in_port = 16'h0008;
        repeat (5) @(negedge clk);
        bus_rd(2'd3);
        chk("fall_no_rise", rd0, 32'h0);
        chk("fall_no_rise_w4", rd2, 32'h0);

        // Per-bit versus clear-all.
        bus_wr(2'd1, 32'h5555_5555);
        in_port = 16'h0029;
        repeat (5) @(negedge clk);
        bus_rd(2'd3);
        chk("cap_b05", rd0, 32'h21);
        chk("cap_b05_w4", rd2, 32'h1);
        bus_wr(2'd3, 32'h1);
        bus_rd(2'd3);
        chk("w1c_bit", rd0, 32'h20);
        chk("clr_all", rd1, 32'h0);

        // Clear write lands on the same edge that sets bit 2.
        in_port = 16'h002d;
        repeat (2) @(negedge clk);
        bus_wr(2'd3, 32'h4);
        bus_rd(2'd3);
        chk("set_wins", rd0, 32'h24);
        chk("set_wins_clrall", rd1, 32'h4);
        chk("set_wins_w4", rd2, 32'h4);

        // Narrow mask read-back, then reset mid-operation.
        bus_wr(2'd2, 32'hffff_ffff);
        bus_rd(2'd2);
        chk("mask_w4", rd2, 32'h0000_000f);
        chk("mask_w16", rd0, 32'h0000_ffff);
        chk("irq_full_mask", {31'h0, irq0}, 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rd", rd0, 32'h0);
        chk("async_rd_w4", rd2, 32'h0);
        chk("async_irq", {31'h0, irq0}, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        bus_rd(2'd1);
        chk("mode_rst2_w4", rd2, 32'h55);
        bus_rd(2'd2);
        chk("mask_rst2", rd0, 32'h0);
        bus_rd(2'd3);
        chk("spurious_cap", rd0, 32'h2d);
        chk("spurious_cap_w4", rd2, 32'hd);
        chk("irq_rst2", {31'h0, irq0}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
